bit_permute_pipe: RTL and testbench
===================================

# bit_permute_pipe

Parametrised, registered bit-permutation unit that generalises the fixed per-bit assign patterns (identity, reverse, shift, arbitrary shuffle) into one run-time selectable datapath. Sits between a valid/ready producer and consumer as a single-register pipeline stage. An optional writable permutation table allows any bit mapping to be loaded at run time. Used as the reference datapath against which vectorised permutation netlists are equivalence-checked.

## Interface
Parameters:
- `WIDTH`, default 8: data width in bits; any value ≥ 2.
- `IDX_W`, default `$clog2(WIDTH)`: width of bit indices and the shift amount; derived, not overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: input word valid.
- `in_ready`, output, 1: stage can accept a word.
- `in_data`, input, WIDTH: word to permute.
- `in_mode`, input, 2: 0 identity, 1 reverse, 2 logical shift right, 3 table/rotate.
- `in_amt`, input, IDX_W: shift/rotate amount, used in modes 2 and 3-without-table.
- `out_valid`, output, 1: output word valid.
- `out_ready`, input, 1: consumer accepts the output.
- `out_data`, output, WIDTH: permuted word.
- `cfg_we`, input, 1: table write strobe.
- `cfg_idx`, input, IDX_W: destination bit index being configured.
- `cfg_src`, input, IDX_W: source bit index for `cfg_idx`.

## Operation
- Handshake: input accepted when `in_valid && in_ready`; output consumed when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`, combinational. There is no other path from `out_ready` to the inputs.
- The permutation is computed combinationally from `in_data`, `in_mode`, `in_amt` and the table, and registered into `out_data` on accept.
- Mode 0: `out[i] = in[i]`.
- Mode 1: `out[i] = in[WIDTH-1-i]`.
- Mode 2: `out[i] = in[i+amt]` when `i+amt < WIDTH`, otherwise 0.
  - If `amt ≥ WIDTH` (possible for non-power-of-two WIDTH), the output is all zeros.
  - Index arithmetic is carried out in IDX_W+1 bits so it cannot wrap.
- Mode 3: `out[i] = in[tbl[i]]` (see Configuration).
- Table: WIDTH entries of IDX_W bits; reset value `tbl[i] = i` (identity).
  - A write on `cfg_we` sets `tbl[cfg_idx] = cfg_src`.
  - The write is ignored if `cfg_idx ≥ WIDTH` or `cfg_src ≥ WIDTH`.
  - Duplicate sources are legal; the table is a mapping, not a bijection.
- Simultaneous table write and input accept in the same cycle: the accepted word uses the old table. The new entry applies from the next accept.
- Words already held in the output register are never re-permuted by later table writes.
- Output register holds when `out_valid && !out_ready`: `out_data` is stable and `in_ready = 0`.
- If a consume and an accept happen in the same cycle, the new word replaces the old one with no bubble.
- Reset:
  - `out_valid = 0`
  - `out_data = 0`
  - table back to identity
  - takes effect immediately on `rst_n` falling, mid-transfer included
  - any held word is dropped

## Timing
- Latency: 1 cycle; an input accepted at edge N appears on `out_data` with `out_valid = 1` after edge N.
- Throughput: 1 word per cycle while `out_ready = 1`.
- `in_ready` depends combinationally only on `out_valid` (registered) and `out_ready`.
- A table write at edge N is visible to words accepted at edge N+1 or later.
- Reset release is synchronous to `clk` by the integrator; the first accept is possible on the first edge with `rst_n = 1`.

## Configuration
- Macro: `BIT_PERMUTE_TABLE_EN`.
- Defined: the table and `cfg_*` logic are present; mode 3 is the table permutation.
- Undefined: no table storage; the `cfg_*` ports remain but are ignored.
  - Mode 3 becomes rotate right: `out[i] = in[(i+amt) mod WIDTH]`.
  - `amt ≥ WIDTH` is reduced mod WIDTH.

## Test plan
All cases use WIDTH=8.
- Mode 0, `in_data = 8'hA5`, `out_ready = 1` → `out_data = 8'hA5`, `out_valid = 1` one cycle after accept. Back-to-back words 8'h01, 8'h02, 8'h03 emerge on consecutive cycles.
- Mode 1, `8'h01` → `8'h80`. Mode 2, `amt = 2`, `8'hFF` → `8'h3F`. Mode 2, `amt = 7`, `8'h80` → `8'h01`.
- Table enabled: load `tbl = {0:1, 1:2, 2:3, 3:0, 4:5, 5:4, 6:6, 7:7}`. Then mode 3 maps `8'h01` → `8'h08`, `8'h10` → `8'h20`, `8'hC0` → `8'hC0`. Write `cfg_idx = 7`, `cfg_src = 0` in the same cycle as accepting `8'h01` → output `8'h08`; the next `8'h01` → `8'h88`.
- Table disabled: mode 3, `amt = 1`, `8'h01` → `8'h80`. `cfg_we` pulses have no effect.
- Backpressure: hold `out_ready = 0` for 3 cycles with `in_valid = 1` → `out_data` is stable, `in_ready = 0`, no word is lost or duplicated. Releasing `out_ready` delivers the pending words in order.
- Reset mid-operation: `rst_n` low while `out_valid = 1` and the table is non-identity → `out_valid = 0` and `out_data = 0` immediately. After release, mode 3 on `8'h01` → `8'h01` (identity table).

Source files
------------

// File: rtl/bit_permute_pipe.sv
// Single-register valid/ready stage that applies a run-time selectable bit permutation.
// Define BIT_PERMUTE_TABLE_EN for a writable mode-3 table; otherwise mode 3 rotates right.
module bit_permute_pipe #(
  parameter int WIDTH = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [IDX_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [IDX_W-1:0] cfg_src
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] rev_s, sel_s, perm_s;
  logic             accept_s;

  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Bit reversal network.
  always_comb begin
    rev_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev_s[i] = in_data[WIDTH-1-i];
    end
  end

`ifdef BIT_PERMUTE_TABLE_EN
  logic [IDX_W-1:0] tbl_q [WIDTH];
  logic [IDX_W-1:0] tbl_d [WIDTH];
  logic             cfg_ok_s;
  logic             amt_unused_s;

  assign amt_unused_s = 1'b0;
  assign cfg_ok_s = cfg_we
                 && ({1'b0, cfg_idx} < (IDX_W+1)'(WIDTH))
                 && ({1'b0, cfg_src} < (IDX_W+1)'(WIDTH));

  // Table next state: a single validated entry write per cycle.
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_ok_s) begin
      tbl_d[cfg_idx] = cfg_src;
    end else begin
      tbl_d = tbl_q;
    end
  end

  // Table storage, identity after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        tbl_q[i] <= IDX_W'(i);
      end
    end else begin
      tbl_q <= tbl_d;
    end
  end

  // Table gather: the current (pre-write) table feeds the word being accepted.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sel_s[i] = in_data[tbl_q[i]];
    end
  end
`else
  logic [IDX_W-1:0] amt_mod_s;
  logic             cfg_unused_s;

  assign cfg_unused_s = ^{cfg_we, cfg_idx, cfg_src};

  // Rotate amount reduced mod WIDTH; only reachable for non-power-of-two WIDTH.
  always_comb begin
    amt_mod_s = in_amt;
    if ({1'b0, in_amt} >= (IDX_W+1)'(WIDTH)) begin
      amt_mod_s = in_amt - IDX_W'(WIDTH);
    end else begin
      amt_mod_s = in_amt;
    end
  end

  // Rotate right; a zero amount shifts the left term fully out.
  always_comb begin
    sel_s = (in_data >> amt_mod_s)
          | (in_data << ((IDX_W+1)'(WIDTH) - {1'b0, amt_mod_s}));
  end
`endif

  // Mode select; the right shift zero-fills and clears entirely when amt >= WIDTH.
  always_comb begin
    perm_s = in_data;
    case (in_mode)
      2'd0:    perm_s = in_data;
      2'd1:    perm_s = rev_s;
      2'd2:    perm_s = in_data >> in_amt;
      2'd3:    perm_s = sel_s;
      default: perm_s = in_data;
    endcase
  end

  // Output stage next state: load on accept, clear valid on consume, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = perm_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Scoreboard bench for bit_permute_pipe at WIDTH=8; covers the table build when
// BIT_PERMUTE_TABLE_EN is defined, and the rotate build otherwise.
module tb_bit_permute_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_mode = 2'd0;
  logic [2:0] in_amt = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = 3'd0;
  logic [2:0] cfg_src = 3'd0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         mv = 1'b0;
  int         errors = 0;
  int         checks = 0;

  bit_permute_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_amt(in_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_src(cfg_src)
  );

  always #5 clk = ~clk;

  // One clock: record consumed output, push expected for an accepted word.
  task automatic tick(input logic [7:0] exp_w);
    bit acc, con;
    acc = in_valid && (!mv || out_ready);
    con = mv && out_ready;
    if (con) got_q.push_back(out_data);
    if (acc) exp_q.push_back(exp_w);
    @(posedge clk);
    if (acc) mv = 1'b1;
    else if (con) mv = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_in(input logic v, input logic [7:0] d, input logic [1:0] m, input logic [2:0] a);
    in_valid = v; in_data = d; in_mode = m; in_amt = a;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    mv = 1'b0;
  endtask

  task automatic test_modes;
    logic [7:0] g, e;
    out_ready = 1'b1;
    set_in(1'b1, 8'hA5, 2'd0, 3'd0); tick(8'hA5);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++; $display("FAIL latency: got v=%b d=%h expected v=1 d=a5", out_valid, out_data); end
    set_in(1'b1, 8'h01, 2'd1, 3'd0); tick(8'h80);
    set_in(1'b1, 8'hFF, 2'd2, 3'd2); tick(8'h3F);
    set_in(1'b1, 8'h80, 2'd2, 3'd7); tick(8'h01);
    set_in(1'b1, 8'hF0, 2'd2, 3'd0); tick(8'hF0);
    for (int k = 1; k <= 3; k++) begin
      set_in(1'b1, 8'(k), 2'd0, 3'd0); tick(8'(k));
      checks++; if (out_valid !== 1'b1 || out_data !== 8'(k)) begin
        errors++; $display("FAIL back_to_back: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, 8'(k)); end
    end
    set_in(1'b0, 8'h00, 2'd0, 3'd0); tick(8'h00);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", out_valid); end
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL modes_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL modes_word: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

`ifdef BIT_PERMUTE_TABLE_EN
  task automatic test_table;
    logic [7:0] g, e;
    logic [2:0] src_tab [8];
    src_tab = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd4, 3'd6, 3'd7};
    set_in(1'b0, 8'h00, 2'd3, 3'd0);
    for (int k = 0; k < 8; k++) begin
      cfg_we = 1'b1; cfg_idx = 3'(k); cfg_src = src_tab[k];
      tick(8'h00);
    end
    cfg_we = 1'b0;
    set_in(1'b1, 8'h01, 2'd3, 3'd0); tick(8'h08);
    set_in(1'b1, 8'h10, 2'd3, 3'd0); tick(8'h20);
    set_in(1'b1, 8'hC0, 2'd3, 3'd0); tick(8'hC0);
    cfg_we = 1'b1; cfg_idx = 3'd7; cfg_src = 3'd0;
    set_in(1'b1, 8'h01, 2'd3, 3'd0); tick(8'h08);
    cfg_we = 1'b0;
    set_in(1'b1, 8'h01, 2'd3, 3'd0); tick(8'h88);
    set_in(1'b0, 8'h00, 2'd0, 3'd0); tick(8'h00);
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL table_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL table_word: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask
`else
  task automatic test_rotate;
    logic [7:0] g, e;
    set_in(1'b1, 8'h01, 2'd3, 3'd1); tick(8'h80);
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_src = 3'd5;
    set_in(1'b1, 8'h01, 2'd3, 3'd3); tick(8'h20);
    cfg_idx = 3'd7; cfg_src = 3'd0;
    set_in(1'b1, 8'h01, 2'd3, 3'd0); tick(8'h01);
    cfg_we = 1'b0;
    set_in(1'b1, 8'h81, 2'd3, 3'd4); tick(8'h18);
    set_in(1'b0, 8'h00, 2'd0, 3'd0); tick(8'h00);
    checks++; if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rotate_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL rotate_word: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask
`endif

  task automatic test_backpressure;
    logic [7:0] g, e;
    out_ready = 1'b1;
    set_in(1'b1, 8'h11, 2'd0, 3'd0); tick(8'h11);
    out_ready = 1'b0;
    set_in(1'b1, 8'h22, 2'd0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      tick(8'h22);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold: got v=%b d=%h rdy=%b expected v=1 d=11 rdy=0", out_valid, out_data, in_ready); end
    end
    out_ready = 1'b1;
    tick(8'h22);
    set_in(1'b0, 8'h00, 2'd0, 3'd0); tick(8'h00);
    checks++; if (got_q.size() != 2 || exp_q.size() != 2) begin
      errors++; $display("FAIL bp_count: got %0d/%0d expected 2/2", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL bp_word: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] g, e;
    out_ready = 1'b0;
    set_in(1'b1, 8'h5A, 2'd1, 3'd0); tick(8'h5A);
    set_in(1'b0, 8'h00, 2'd0, 3'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got v=%b d=%h expected v=0 d=00", out_valid, out_data); end
    got_q.delete(); exp_q.delete(); mv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 8'h01, 2'd3, 3'd0); tick(8'h01);
    set_in(1'b0, 8'h00, 2'd0, 3'd0); tick(8'h00);
    checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL post_reset_count: got %0d/%0d expected 1/1", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL post_reset_word: got %h expected %h", g, e); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_modes();
`ifdef BIT_PERMUTE_TABLE_EN
    test_table();
`else
    test_rotate();
`endif
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
